// File: rtl/fft_frame_ctrl_if.sv
// Sample-in, frame-to-FFT and bin-out buses of fft_frame_ctrl.
// slave = controller side, master = environment (ADC, fft_dit2, consumer).
interface fft_frame_ctrl_if #(
  parameter int SIZE = 64,
  parameter int RN   = 16
);
  localparam int AW = $clog2(SIZE);

  logic                         in_valid;
  logic                         in_ready;
  logic [RN-1:0]                in_re;
  logic [RN-1:0]                in_im;
  logic [SIZE-1:0][1:0][RN-1:0] fft_in;
  logic                         fft_done;
  logic [SIZE-1:0][1:0][RN-1:0] fft_out;
  logic                         out_valid;
  logic                         out_ready;
  logic [RN-1:0]                out_re;
  logic [RN-1:0]                out_im;
  logic [AW-1:0]                out_idx;
  logic                         out_last;
  logic                         busy;
  logic [15:0]                  frame_cnt;
  logic [15:0]                  drop_cnt;

  modport slave (
    input  in_valid, in_re, in_im, fft_done, fft_out, out_ready,
    output in_ready, fft_in, out_valid, out_re, out_im, out_idx, out_last,
           busy, frame_cnt, drop_cnt
  );

  modport master (
    output in_valid, in_re, in_im, fft_done, fft_out, out_ready,
    input  in_ready, fft_in, out_valid, out_re, out_im, out_idx, out_last,
           busy, frame_cnt, drop_cnt
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer around a free-running fft_dit2: fill, hold, capture, drain.
// Define FFT_CTRL_DROP_EN to drop (and count) samples offered while waiting.
module fft_frame_ctrl #(
  parameter int SIZE    = 64,
  parameter int RN      = 16,
  parameter int DISCARD = 2
) (
  input  logic            clk,
  input  logic            n_reset,
  fft_frame_ctrl_if.slave bus
);
  localparam int          AW   = $clog2(SIZE);
  localparam logic [3:0]  DISC = 4'(DISCARD);
  localparam logic [AW-1:0] LAST = AW'(SIZE - 1);

  typedef enum logic {FILL, WAIT}  in_st_t;
  typedef enum logic {IDLE, DRAIN} out_st_t;

  in_st_t  r_in_st,  w_in_nxt;
  out_st_t r_out_st, w_out_nxt;

  logic [AW-1:0]                r_wr_idx;
  logic [3:0]                   r_done_cnt;
  logic [SIZE-1:0][1:0][RN-1:0] r_fft_in;
  logic [SIZE-1:0][1:0][RN-1:0] r_cap;
  logic [RN-1:0]                r_out_re, r_out_im;
  logic [AW-1:0]                r_out_idx;
  logic                         r_out_last;
  logic [15:0]                  r_frame_cnt;

  logic          w_acc, w_cap, w_hs, w_wr_last;
  logic [AW-1:0] w_nxt_idx;

  assign w_nxt_idx = r_out_idx + 1'b1;

  always_comb begin
    w_in_nxt  = r_in_st;
    w_out_nxt = r_out_st;
    w_acc     = 1'b0;
    w_cap     = 1'b0;
    w_hs      = 1'b0;
    w_wr_last = (r_wr_idx == LAST);
    case (r_in_st)
      FILL: begin
        w_acc = bus.in_valid;
        if (w_acc && w_wr_last) w_in_nxt = WAIT;
      end
      WAIT: begin
        // Output must already be registered IDLE, so capture never meets the last beat.
        w_cap = (r_done_cnt == DISC) && (r_out_st == IDLE);
        if (w_cap) w_in_nxt = FILL;
      end
      default: ;
    endcase
    case (r_out_st)
      IDLE:  if (w_cap) w_out_nxt = DRAIN;
      DRAIN: begin
        w_hs = bus.out_ready;
        if (w_hs && r_out_last) w_out_nxt = IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_in_st  <= FILL;
      r_out_st <= IDLE;
    end else begin
      r_in_st  <= w_in_nxt;
      r_out_st <= w_out_nxt;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_idx    <= '0;
      r_done_cnt  <= '0;
      r_frame_cnt <= '0;
      r_fft_in    <= '0;
    end else begin
      if (w_acc) begin
        r_fft_in[r_wr_idx] <= {bus.in_im, bus.in_re};
        r_wr_idx           <= w_wr_last ? '0 : r_wr_idx + 1'b1;
      end
      // A done pulse in the cycle we enter WAIT belongs to the previous frame.
      if (w_acc && w_wr_last)
        r_done_cnt <= '0;
      else if (r_in_st == WAIT && bus.fft_done && r_done_cnt != DISC)
        r_done_cnt <= r_done_cnt + 1'b1;
      if (w_cap) r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  // Bin 0 is loaded straight from fft_out so it is valid together with out_valid.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_cap      <= '0;
      r_out_re   <= '0;
      r_out_im   <= '0;
      r_out_idx  <= '0;
      r_out_last <= 1'b0;
    end else if (w_cap) begin
      r_cap      <= bus.fft_out;
      r_out_re   <= bus.fft_out[0][0];
      r_out_im   <= bus.fft_out[0][1];
      r_out_idx  <= '0;
      r_out_last <= 1'b0;
    end else if (w_hs) begin
      if (r_out_last) begin
        r_out_last <= 1'b0;
      end else begin
        r_out_idx  <= w_nxt_idx;
        r_out_re   <= r_cap[w_nxt_idx][0];
        r_out_im   <= r_cap[w_nxt_idx][1];
        r_out_last <= (w_nxt_idx == LAST);
      end
    end
  end

`ifdef FFT_CTRL_DROP_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)
      r_drop_cnt <= '0;
    else if (r_in_st == WAIT && bus.in_valid && r_drop_cnt != 16'hFFFF)
      r_drop_cnt <= r_drop_cnt + 1'b1;
  end

  assign bus.in_ready = n_reset;
  assign bus.drop_cnt = r_drop_cnt;
`else
  assign bus.in_ready = (r_in_st == FILL);
  assign bus.drop_cnt = 16'd0;
`endif

  assign bus.busy      = (r_in_st == WAIT);
  assign bus.fft_in    = r_fft_in;
  assign bus.out_valid = (r_out_st == DRAIN);
  assign bus.out_re    = r_out_re;
  assign bus.out_im    = r_out_im;
  assign bus.out_idx   = r_out_idx;
  assign bus.out_last  = r_out_last;
  assign bus.frame_cnt = r_frame_cnt;
endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer for the free-running `fft_dit2` butterfly tree. It collects a serial complex sample stream into a held input frame and keeps that frame stable while the FFT settles. It then captures the transform into a result buffer and streams the bins out serially with a valid/ready handshake. It sits between the ADC sample path and the spectrum consumer (display/readout), and overlaps filling the next frame with draining the previous one.

## Interface
- `SIZE`, 64: FFT points. Power of two, 4..128, matching the attached `fft_dit2`.
- `RN`, 16: bits per real/imag component.
- `DISCARD`, 2: `fft_done` pulses ignored after a frame is loaded before results count as valid. Range 1..15.
- `clk`  in  1  sole clock, rising edge.
- `n_reset`  in  1  reset, asynchronous assert, active low.
- `in_valid`  in  1  sample offered.
- `in_ready`  out  1  sample accepted when `in_valid && in_ready`.
- `in_re`, `in_im`  in  RN each  sample components.
- `fft_in`  out  [SIZE][2] x RN  held frame driving `fft_dit2.in`.
- `fft_done`  in  1  `fft_dit2.done`.
- `fft_out`  in  [SIZE][2] x RN  `fft_dit2.out`.
- `out_valid`  out  1  bin offered.
- `out_ready`  in  1  consumer accepts the bin.
- `out_re`, `out_im`  out  RN each  bin components.
- `out_idx`  out  $clog2(SIZE)  bin index.
- `out_last`  out  1  high with bin SIZE-1.
- `busy`  out  1  input FSM is not in FILL.
- `frame_cnt`  out  16  frames captured; wraps at 65535 to 0.
- `drop_cnt`  out  16  samples dropped; saturates at 65535.

## Operation
- Input FSM, states FILL / WAIT:
  - FILL: `in_ready`=1. Each accepted sample writes `fft_in[wr_idx]` and increments `wr_idx`. Accepting at `wr_idx`=SIZE-1 clears `wr_idx` and `done_cnt` and moves to WAIT.
  - WAIT: `in_ready`=0 (see Configuration). Each `fft_done` high cycle increments `done_cnt`, which saturates at DISCARD.
  - Capture condition: `done_cnt`==DISCARD and the output FSM is in IDLE. On capture:
    - `cap <= fft_out` (whole array, one cycle);
    - input FSM goes to FILL;
    - output FSM goes to DRAIN with `rd_idx`=0;
    - `frame_cnt` increments.
  - If the output FSM is still in DRAIN, WAIT holds. `fft_in` stays stable, so the results stay valid.
- Output FSM, states IDLE / DRAIN:
  - DRAIN: `out_valid`=1, `out_re/out_im`=`cap[rd_idx]`, `out_idx`=`rd_idx`. On each handshake `rd_idx` increments.
  - Handshake at `rd_idx`=SIZE-1 (`out_last`=1) goes to IDLE. `out_valid` drops the next cycle.
- `fft_in` changes only in FILL. Stale entries beyond `wr_idx` are never read before being overwritten.
- Arithmetic: no transformation of data. Components pass through bit-exact.

## Timing
- All outputs are registered except `in_ready` and `busy`, which decode the state register.
- Reset values: input FSM FILL, `in_ready`=1, `busy`=0, output FSM IDLE, `out_valid`=0, `out_last`=0, `out_idx`=0, `out_re`=`out_im`=0, `fft_in` all 0, `frame_cnt`=`drop_cnt`=0, `done_cnt`=0.
- Last sample accepted in cycle T: WAIT from T+1. The earliest capture is the cycle after the DISCARD-th `fft_done` pulse seen from T+1. `out_valid` rises the cycle after capture.
- Capture cannot coincide with the last output beat: IDLE is required as a registered state, so there is at least one idle cycle between frames on the output.
- `fft_done` in the same cycle as the transition into WAIT is not counted.
- `out_valid` holds and data stays stable until `out_ready`. There is no combinational path from `out_ready` to `in_ready`.
- `n_reset` low mid-frame: partial input and partial drain are discarded. The block resumes in FILL/IDLE with the counters cleared.

## Configuration
- `FFT_CTRL_DROP_EN` defined:
  - `in_ready` is constantly 1 (0 only while in reset).
  - Samples offered in WAIT are discarded; each one increments `drop_cnt`.
- `FFT_CTRL_DROP_EN` undefined:
  - Back-pressure. `in_ready`=0 in WAIT.
  - `drop_cnt` is tied to 0.

## Test plan
- SIZE=8 with the real `fft_dit2` (FRAC=8). Impulse (256,0) followed by seven zeros -> 8 bins of (256,0), `out_idx` 0..7, `out_last` only on idx 7, `frame_cnt`=1.
- DC input of 8x(64,0) -> bin0=(512,0), bins 1..7=(0,0). Hold `out_ready` low for 5 cycles mid-drain -> data and `out_idx` stable throughout, no beat lost.
- Bench `fft_done` stub pulsing every 4 cycles, DISCARD=2 -> capture exactly 1 cycle after the 2nd pulse following the last sample, and `out_valid` 1 cycle later.
- Consumer stalled, second frame fully loaded -> `busy`=1 and capture deferred until output is IDLE. The second frame's bins then match its own input, not the first frame's.
- With `FFT_CTRL_DROP_EN`, offer 5 samples during WAIT -> `drop_cnt`=5 and the next frame starts at the first sample after capture. Without the macro -> `in_ready`=0 in WAIT, `drop_cnt`=0.
- Assert `n_reset` after 3 of 8 samples -> all outputs at reset values. A fresh 8-sample frame then produces the correct spectrum.
